// File: rtl/energy_stream_if.sv
// Stream/control bundle between the J streamer, the spin-update controller
// and the energy engine.
interface energy_stream_if #(
    parameter int VECTOR_SIZE   = 256,
    parameter int J_W           = 4,
    parameter int COLS_PER_BEAT = 4,
    parameter int ENERGY_W      = 2*$clog2(VECTOR_SIZE)+J_W+1
);
    logic                                    start;
    logic                                    abort;
    logic [VECTOR_SIZE-1:0]                  sigma;
    logic [ENERGY_W-1:0]                     energy_prev;
    logic                                    j_valid;
    logic                                    j_ready;
    logic [VECTOR_SIZE*COLS_PER_BEAT*J_W-1:0] j_chunk;
    logic                                    busy;
    logic                                    energy_valid;
    logic [ENERGY_W-1:0]                     energy_out;
    logic                                    energy_exceeded;

    modport master (
        output start, abort, sigma, energy_prev, j_valid, j_chunk,
        input  j_ready, busy, energy_valid, energy_out, energy_exceeded
    );
    modport slave (
        input  start, abort, sigma, energy_prev, j_valid, j_chunk,
        output j_ready, busy, energy_valid, energy_out, energy_exceeded
    );
endinterface

// File: rtl/energy_stream_engine.sv
// Streaming Ising energy sigma^T*J*sigma: J arrives as column chunks, sigma
// is latched per job, one signed energy result per completed job.
module energy_stream_engine #(
    parameter int VECTOR_SIZE   = 256,
    parameter int J_W           = 4,
    parameter int COLS_PER_BEAT = 4,
    parameter int J_SIGNED      = 0,
    parameter int NUM_CHUNKS    = VECTOR_SIZE/COLS_PER_BEAT,
    parameter int ENERGY_W      = 2*$clog2(VECTOR_SIZE)+J_W+1
) (
    input logic            clk,
    input logic            rst,
    energy_stream_if.slave bus
);
    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int IDX_W = $clog2(VECTOR_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state, state_nxt;
    logic [VECTOR_SIZE-1:0]     sig_l;
    logic signed [ENERGY_W-1:0] prev_l, acc, energy_q, blk;
    logic                       exc_q;
    logic [CNT_W-1:0]           cnt;
    logic                       accept, last, commit, launch;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = (state == IDLE) && bus.start && !bus.abort;
        accept    = bus.j_valid && (state == RUN) && !bus.abort;
        last      = (cnt == CNT_W'(NUM_CHUNKS-1));
        // abort in DONE suppresses the result for that cycle
        commit    = (state == DONE) && !bus.abort;
        unique case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (bus.abort) state_nxt = IDLE;
                     else if (accept && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.j_ready         = (state == RUN) && !bus.abort;
    assign bus.busy            = (state == RUN);
    assign bus.energy_valid    = commit;
    assign bus.energy_out      = commit ? acc : energy_q;
    assign bus.energy_exceeded = commit ? (acc >= prev_l) : exc_q;

    // Per beat: dot_c over all rows, then fold columns with their own spin.
    always_comb begin
        logic [J_W-1:0]             elem;
        logic signed [ENERGY_W-1:0] jv, dot;
        logic [IDX_W-1:0]           gi;
        blk  = '0;
        elem = '0;
        jv   = '0;
        dot  = '0;
        gi   = '0;
        for (int c = 0; c < COLS_PER_BEAT; c++) begin
            gi  = IDX_W'(int'(cnt) * COLS_PER_BEAT + c);
            dot = '0;
            for (int r = 0; r < VECTOR_SIZE; r++) begin
                elem = bus.j_chunk[(r*COLS_PER_BEAT + c)*J_W +: J_W];
                jv   = {{(ENERGY_W-J_W){(J_SIGNED != 0) & elem[J_W-1]}}, elem};
                dot  = sig_l[r] ? dot + jv : dot - jv;
            end
            blk = sig_l[gi] ? blk + dot : blk - dot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_l    <= '0;
            prev_l   <= '0;
            acc      <= '0;
            cnt      <= '0;
            energy_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            if (launch) begin
                sig_l  <= bus.sigma;
                prev_l <= bus.energy_prev;
                acc    <= '0;
                cnt    <= '0;
            end
            if (accept) begin
                acc <= acc + blk;
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (commit) begin
                energy_q <= acc;
                exc_q    <= (acc >= prev_l);
            end
        end
    end
endmodule

// File: tb/tb_energy_stream_engine.sv
// Directed bench: unsigned-J and signed-J engines driven in lockstep,
// N=4, 2 columns/beat, 2 beats per job.
module tb_energy_stream_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, j_valid = 1'b0;
    logic [3:0]  sigma = '0;
    logic [8:0]  energy_prev = '0;
    logic [31:0] j_chunk = '0;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    energy_stream_if #(.VECTOR_SIZE(4), .J_W(4), .COLS_PER_BEAT(2), .ENERGY_W(9)) if0 ();
    energy_stream_if #(.VECTOR_SIZE(4), .J_W(4), .COLS_PER_BEAT(2), .ENERGY_W(9)) if1 ();

    assign if0.start = start;   assign if1.start = start;
    assign if0.abort = abort;   assign if1.abort = abort;
    assign if0.sigma = sigma;   assign if1.sigma = sigma;
    assign if0.energy_prev = energy_prev;  assign if1.energy_prev = energy_prev;
    assign if0.j_valid = j_valid;  assign if1.j_valid = j_valid;
    assign if0.j_chunk = j_chunk;  assign if1.j_chunk = j_chunk;

    energy_stream_engine #(.VECTOR_SIZE(4), .J_W(4), .COLS_PER_BEAT(2), .J_SIGNED(0))
        dut_u (.clk(clk), .rst(rst), .bus(if0));
    energy_stream_engine #(.VECTOR_SIZE(4), .J_W(4), .COLS_PER_BEAT(2), .J_SIGNED(1))
        dut_s (.clk(clk), .rst(rst), .bus(if1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // element (r,c) of beat k = 4*r + global column
    function automatic logic [31:0] ramp(input int k);
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 2; c++)
                v[(r*2+c)*4 +: 4] = 4'(4*r + 2*k + c);
        return v;
    endfunction

    task automatic job(input string nm, input logic [3:0] sg, input logic [8:0] ep,
                       input logic [31:0] c0, input logic [31:0] c1, input int gap,
                       input int e0, input int x0, input bit ck1, input int e1, input int x1);
        sigma = sg; energy_prev = ep; start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int g = 0; g < gap; g++) begin
                j_valid = 1'b0; #1;
                chk({nm, "_gap_busy"}, if0.busy, 1);
                chk({nm, "_gap_ev"}, if0.energy_valid, 0);
                tick();
            end
            j_chunk = (b == 0) ? c0 : c1; j_valid = 1'b1; #1;
            chk({nm, "_ready"}, if0.j_ready, 1);
            tick();
        end
        j_valid = 1'b0; #1;
        chk({nm, "_ev"}, if0.energy_valid, 1);
        chk({nm, "_eo"}, $signed(if0.energy_out), e0);
        chk({nm, "_ex"}, if0.energy_exceeded, x0);
        chk({nm, "_busy"}, if0.busy, 0);
        if (ck1) begin
            chk({nm, "_s_ev"}, if1.energy_valid, 1);
            chk({nm, "_s_eo"}, $signed(if1.energy_out), e1);
            chk({nm, "_s_ex"}, if1.energy_exceeded, x1);
        end
        tick();
        chk({nm, "_ev_off"}, if0.energy_valid, 0);
        chk({nm, "_eo_hold"}, $signed(if0.energy_out), e0);
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_ready", if0.j_ready, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_ev", if0.energy_valid, 0);
        chk("rst_eo", $signed(if0.energy_out), 0);
        chk("rst_ex", if0.energy_exceeded, 0);
        tick();

        job("ones_f",  4'b1111, 9'h000, 32'h11111111, 32'h11111111, 0, 16, 1, 1, 16, 1);
        job("ones_3",  4'b0011, 9'h000, 32'h11111111, 32'h11111111, 0, 0,  1, 1, 0,  1);
        job("ones_0",  4'b0000, 9'h000, 32'h11111111, 32'h11111111, 0, 16, 1, 1, 16, 1);
        job("neg",     4'b1111, 9'h1F6, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 240, 1, 1, -16, 0);
        job("ramp",    4'b0001, 9'd60,  ramp(0), ramp(1), 0, 60, 1, 0, 0, 0);
        job("ramp_gap",4'b0001, 9'd61,  ramp(0), ramp(1), 3, 60, 0, 0, 0, 0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0; #1;
        chk("sa_busy", if0.busy, 0);

        // abort after first beat, with a beat offered in the same cycle
        sigma = 4'b1111; energy_prev = 9'h000; start = 1'b1;
        tick();
        start = 1'b0; j_chunk = 32'h11111111; j_valid = 1'b1;
        tick();
        abort = 1'b1; #1;
        chk("ab_ready", if0.j_ready, 0);
        tick();
        abort = 1'b0; j_valid = 1'b0; #1;
        chk("ab_busy", if0.busy, 0);
        chk("ab_ev", if0.energy_valid, 0);
        chk("ab_eo", $signed(if0.energy_out), 60);
        chk("ab_ex", if0.energy_exceeded, 0);
        job("after_ab", 4'b1111, 9'h000, 32'h11111111, 32'h11111111, 0, 16, 1, 1, 16, 1);

        // start while busy and sigma change mid-run are ignored
        sigma = 4'b0000; energy_prev = 9'd17; start = 1'b1;
        tick();
        start = 1'b0; j_chunk = 32'h11111111; j_valid = 1'b1;
        tick();
        start = 1'b1; sigma = 4'b0011; energy_prev = 9'd0;
        tick();
        start = 1'b0; j_valid = 1'b0; #1;
        chk("sb_ev", if0.energy_valid, 1);
        chk("sb_eo", $signed(if0.energy_out), 16);
        chk("sb_ex", if0.energy_exceeded, 0);
        tick();
        chk("sb_idle", if0.busy, 0);

        // reset mid-job
        sigma = 4'b1111; energy_prev = 9'h000; start = 1'b1;
        tick();
        start = 1'b0; j_valid = 1'b1;
        tick();
        rst = 1'b1; j_valid = 1'b0;
        tick();
        chk("mr_busy", if0.busy, 0);
        chk("mr_ready", if0.j_ready, 0);
        chk("mr_ev", if0.energy_valid, 0);
        chk("mr_eo", $signed(if0.energy_out), 0);
        chk("mr_ex", if0.energy_exceeded, 0);
        rst = 1'b0;
        tick();
        job("after_rst", 4'b0000, 9'h000, 32'h11111111, 32'h11111111, 0, 16, 1, 1, 16, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
